// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N_IN:1 mux tree, one 2:1 level per pipeline stage.
// Each stage is a register slice with valid/ready backpressure. Empty stages
// accept new items even while the output is stalled, so bubbles collapse.
// Optional feature macro: MUX_TREE_SEL_ECHO_EN adds out_sel, which carries the
// full original select of the item currently on out_data.
module mux_tree_pipe #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 16,
    parameter int SEL_W  = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef MUX_TREE_SEL_ECHO_EN
    ,
    output logic [SEL_W-1:0]       out_sel
`endif
);

    localparam int LEVELS = SEL_W;

    for (genvar k = 0; k < LEVELS; k++) begin : lvl
        localparam int LI = N_IN >> k;
        localparam int LO = N_IN >> (k + 1);

        logic [LI*DATA_W-1:0] din;
        logic [LO*DATA_W-1:0] mux;
        logic [LO*DATA_W-1:0] dat_p;
        logic                 vin;
        logic                 vld_p;
        logic                 rdy;
        logic                 sb;

        // Stage inputs: primary inputs for level 0, previous stage otherwise
        if (k == 0) begin : g_in
            assign din = in_data;
            assign vin = in_valid;
        end else begin : g_in
            assign din = lvl[k-1].dat_p;
            assign vin = lvl[k-1].vld_p;
        end

        // A stage can load when it is empty or its successor is loading too
        if (k == LEVELS - 1) begin : g_rdy
            assign rdy = !vld_p || out_ready;
        end else begin : g_rdy
            assign rdy = !vld_p || lvl[k+1].rdy;
        end

`ifdef MUX_TREE_SEL_ECHO_EN
        logic [SEL_W-1:0] sin;
        logic [SEL_W-1:0] sel_p;

        if (k == 0) begin : g_sin
            assign sin = in_sel;
        end else begin : g_sin
            assign sin = lvl[k-1].sel_p;
        end
        assign sb = sin[k];

        // Full select travels with the item so it can be echoed at the output
        always_ff @(posedge clk) begin
            if (rst) begin
                sel_p <= '0;
            end else if (rdy && vin) begin
                sel_p <= sin;
            end
        end
`else
        // Incoming select holds bits [SEL_W-1:k]; bit k sits at index 0
        localparam int SI = SEL_W - k;
        logic [SI-1:0] sin;

        if (k == 0) begin : g_sin
            assign sin = in_sel;
        end else begin : g_sin
            assign sin = lvl[k-1].g_sel.sel_p;
        end
        assign sb = sin[0];

        if (SI > 1) begin : g_sel
            logic [SI-2:0] sel_p;

            // Keep only the select bits later levels still need
            always_ff @(posedge clk) begin
                if (rst) begin
                    sel_p <= '0;
                end else if (rdy && vin) begin
                    sel_p <= sin[SI-1:1];
                end
            end
        end
`endif

        // 2:1 selection over lane pairs (2j, 2j+1)
        always_comb begin
            mux = '0;
            for (int j = 0; j < LO; j++) begin
                mux[j*DATA_W +: DATA_W] = sb ? din[(2*j+1)*DATA_W +: DATA_W]
                                             : din[(2*j)*DATA_W +: DATA_W];
            end
        end

        // Valid advances whenever the stage is ready; data loads only for a valid item
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p <= 1'b0;
                dat_p <= '0;
            end else if (rdy) begin
                vld_p <= vin;
                if (vin) begin
                    dat_p <= mux;
                end
            end
        end
    end

    assign in_ready  = lvl[0].rdy;
    assign out_data  = lvl[LEVELS-1].dat_p;
    assign out_valid = lvl[LEVELS-1].vld_p;
`ifdef MUX_TREE_SEL_ECHO_EN
    assign out_sel   = lvl[LEVELS-1].sel_p;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: directed and randomized checks for mux_tree_pipe
// (DATA_W=8, N_IN=16). Build with MUX_TREE_SEL_ECHO_EN defined to also check out_sel.
module tb_mux_tree_pipe;

    localparam int DATA_W = 8;
    localparam int N_IN   = 16;
    localparam int SEL_W  = 4;
    localparam int N_RAND = 300;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_ready;
`ifdef MUX_TREE_SEL_ECHO_EN
    logic [SEL_W-1:0]       out_sel;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_tree_pipe #(.DATA_W(DATA_W), .N_IN(N_IN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_TREE_SEL_ECHO_EN
        ,
        .out_sel  (out_sel)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_lanes();
        for (int i = 0; i < N_IN; i++) begin
            in_data[i*DATA_W +: DATA_W] = 8'(8'hA0 + i);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SEL_W-1:0]  s2 [4];
        logic [SEL_W-1:0]  s3 [6];
        logic [7:0]        e2 [4];
        logic [DATA_W-1:0] exp_q [$];
        logic [SEL_W-1:0]  sel_q [$];
        int idx, oc, cyc, sent, got;

        s2 = '{4'd0, 4'd15, 4'd7, 4'd8};
        e2 = '{8'hA0, 8'hAF, 8'hA7, 8'hA8};
        s3 = '{4'd3, 4'd9, 4'd12, 4'd1, 4'd6, 4'd14};

        // ---- 1: reset state and single item latency
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; out_ready = 1'b1;
        fill_lanes();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef MUX_TREE_SEL_ECHO_EN
        chk("rst_out_sel", out_sel, 0);
`endif
        in_valid = 1'b1; in_sel = 4'd5;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("t1_early_valid", out_valid, 0);
            chk("t1_in_ready", in_ready, 1);
            @(negedge clk);
        end
        #1;
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 8'hA5);
`ifdef MUX_TREE_SEL_ECHO_EN
        chk("t1_sel", out_sel, 5);
`endif
        @(negedge clk);
        #1;
        chk("t1_valid_drop", out_valid, 0);

        // ---- 2: back-to-back items
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = s2[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_valid", out_valid, 1);
            chk("t2_data", out_data, e2[i]);
            @(negedge clk);
        end
        #1;
        chk("t2_empty", out_valid, 0);

        // ---- 3: stall with 6 offered items, then drain
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) in_sel = s3[idx];
            #1;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b1; in_sel = s3[idx];
        #1;
        chk("t3_accepts", idx, 4);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_valid", out_valid, 1);
        chk("t3_data", out_data, 8'hA3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("t3_hold", out_data, 8'hA3);
        end
        @(negedge clk);
        oc = 0; cyc = 0;
        while (oc < 6 && cyc < 40) begin
            in_valid = (idx < 6);
            if (idx < 6) in_sel = s3[idx];
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                chk("t3_order", out_data, 8'hA0 + 8'(s3[oc]));
                oc++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("t3_count", oc, 6);
        #1;
        chk("t3_empty", out_valid, 0);

        // ---- 4: bubble collapse under stall
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd2;
        #1;
        chk("t4_rdy_a", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1; in_sel = 4'd11;
        #1;
        chk("t4_rdy_b", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("t4_first_valid", out_valid, 1);
        chk("t4_first_data", out_data, 8'hA2);
        @(negedge clk);
        #1;
        chk("t4_second_valid", out_valid, 1);
        chk("t4_second_data", out_data, 8'hAB);
        @(negedge clk);
        #1;
        chk("t4_empty", out_valid, 0);

        // ---- 5: reset with items in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sel = 4'(4 + i);
            @(negedge clk);
        end
        rst = 1'b1; in_valid = 1'b1; in_sel = 4'd7;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_in_ready", in_ready, 1);
`ifdef MUX_TREE_SEL_ECHO_EN
        chk("t5_sel", out_sel, 0);
`endif
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            chk("t5_no_stale", out_valid, 0);
        end

        // ---- 6: random data, select, input gaps and output stalls
        @(negedge clk);
        sent = 0; got = 0; cyc = 0;
        while (got < N_RAND && cyc < 6000) begin
            in_valid = ($urandom_range(0, 3) != 0) && (sent < N_RAND);
            in_sel = SEL_W'($urandom_range(0, N_IN - 1));
            for (int i = 0; i < N_IN; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data[in_sel*DATA_W +: DATA_W]);
                sel_q.push_back(in_sel);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("r_spurious_out", 32'(exp_q.size()), 1);
                end else begin
                    chk("r_data", out_data, exp_q.pop_front());
`ifdef MUX_TREE_SEL_ECHO_EN
                    chk("r_sel", out_sel, sel_q[0]);
`endif
                    void'(sel_q.pop_front());
                    got++;
                end
            end
            chk("r_inflight", 32'(exp_q.size() <= 4), 1);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("r_count", got, N_RAND);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
